fb_access_arbiter: RTL
======================

Name: fb_access_arbiter

Overview:
- Owns the single port of the framebuffer RAM and shares it between three users: the display scan-out reader, the draw-side writer and an internal clear engine.
- Display reads use the upscaled address mapping: buffer pixel = (display_y >> k) * BUF_WIDTH + (display_x >> k), where S = 2^k is the upscale factor.
- With S > 1, the display needs the port only once every S active clocks; all other clocks are write slots.
- Sits between the video timing generator and the framebuffer BRAM in the display subsystem.

Parameters:
- BUF_WIDTH, 160, framebuffer width in pixels.
- BUF_HEIGHT, 120, framebuffer height in pixels.
- H_RES, 640, active display width.
- V_RES, 480, active display height.
- DATA_W, 12, pixel width in bits (RGB444).
- ADDR_W, $clog2(BUF_WIDTH*BUF_HEIGHT), RAM address width (derived).

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- display_active  in  1  timing generator: coordinates valid and in the visible area
- display_x  in  10  horizontal display coordinate
- display_y  in  10  vertical display coordinate
- pixel_out  out  DATA_W  pixel for the display pipeline
- pixel_valid  out  1  pixel_out corresponds to an active coordinate
- wr_valid  in  1  draw-side write request
- wr_ready  out  1  write accepted this cycle when asserted together with wr_valid
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- clear_start  in  1  single-cycle pulse: fill the whole buffer with clear_color
- clear_color  in  DATA_W  fill value, sampled when the clear is accepted
- clear_busy  out  1  clear in progress
- clear_done  out  1  single-cycle pulse when the clear completes
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one clock after a read is issued

Behaviour:
- S is fixed at elaboration: 4 if BUF_WIDTH*4 == H_RES and BUF_HEIGHT*4 == V_RES; else 2 if the ×2 relation holds for both; else 1.
- Display slot: display_active && (display_x & (S-1)) == 0. Display has absolute priority in that cycle.
- Read issue (cycle N): mem_en=1, mem_we=0, mem_addr = scaled address, driven combinationally from the inputs.
- Read return: at the clock edge ending cycle N+1, pixel_out loads mem_rdata.
  - pixel_out holds that value until the next read return.
  - pixel_valid = display_active delayed by 2 clocks.
  - Total latency: coordinate presented in cycle N → pixel visible in cycle N+2. The timing generator leads by 2 clocks.
  - When the 2-cycle-delayed display_active is 0, pixel_out is loaded with 0.
- Address arithmetic: computed in ADDR_W+1 bits, then truncated. Coordinates outside the buffer cannot occur while display_active=1; no bounds check.
- FSM states: IDLE, CLEAR.
- IDLE:
  - wr_ready = !display_slot; wr_ready never depends on wr_valid.
  - A handshake drives mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data in the same cycle.
  - clear_start → CLEAR next cycle; clear_color latched and clear counter set to 0.
- CLEAR:
  - wr_ready=0, clear_busy=1.
  - In every non-display-slot cycle: write the latched colour at the counter address, then increment the counter.
  - After writing address BUF_WIDTH*BUF_HEIGHT-1: return to IDLE and pulse clear_done for 1 cycle; clear_busy falls in the same cycle.
  - clear_start in CLEAR is ignored.
- Simultaneous clear_start and write handshake in IDLE: the write completes that cycle; the clear starts next cycle.
- No port use in a cycle: mem_en=0; mem_addr, mem_wdata and mem_we are 0.
- Reset (asynchronous, any time, including mid-clear):
  - State returns to IDLE; clear counter and latched colour are cleared.
  - pixel_out, pixel_valid, clear_busy and clear_done go to 0; the read pipeline is flushed.
  - An aborted clear produces no clear_done.
- Outputs while rst_n=0: mem_en=0, mem_we=0, wr_ready=0.

Decomposition:
- Package fb_access_pkg holds:
  - the scale-factor function returning 1, 2 or 4 from the buffer and display sizes;
  - the ADDR_W derivation;
  - the state enum fb_arb_state_t {IDLE, CLEAR}.
- One sub-module, fb_scaled_addr_gen: purely combinational coordinate-to-address mapping plus the display_slot flag. It is reused by the sprite-overlay path.

Test Plan:
- Scaled read address: S=4 (160x120 on 640x480), display_active=1, x=13, y=9 → mem_addr=323 with mem_we=0 in that cycle; pixel_out equals RAM[323] two cycles later, with pixel_valid=1.
- Slot sharing: S=4, wr_valid held high across an active line, x=0..7 → wr_ready=0 at x=0 and x=4, 1 at the other six cycles; exactly 6 writes land in RAM.
- Blanking clear: display_active=0, clear_start with clear_color=12'hF00 → clear_busy high for 19200 cycles; clear_done pulses once; all 19200 words read back 12'hF00.
- Clear under scan-out: same clear during active video with S=4 → completes in 25600 cycles, since one slot in 4 is taken by the display; display reads are unaffected and wr_ready stays 0 throughout.
- Simultaneous events: write handshake (addr 5, data 12'h0AB) in the same cycle as clear_start → addr 5 written first; the clear then overwrites it with clear_color.
- Reset mid-clear: rst_n low at clear count 1000 → all outputs 0 immediately; no clear_done; after release, wr_ready=1 in the first non-display cycle.

Source files
------------

// File: rtl/fb_access_pkg.sv
// Shared types and elaboration-time helpers for the framebuffer port arbiter
// and the scaled display address generator.
package fb_access_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_arb_state_t;

  // Integer upscale factor from buffer to display: 4, 2, or 1 if neither fits.
  function automatic int fb_scale_factor(input int buf_w, input int buf_h,
                                         input int h_res, input int v_res);
    if ((buf_w * 4 == h_res) && (buf_h * 4 == v_res)) return 4;
    if ((buf_w * 2 == h_res) && (buf_h * 2 == v_res)) return 2;
    return 1;
  endfunction

  function automatic int fb_scale_log2(input int scale);
    return (scale == 4) ? 2 : ((scale == 2) ? 1 : 0);
  endfunction

  function automatic int fb_addr_width(input int buf_w, input int buf_h);
    return $clog2(buf_w * buf_h);
  endfunction

endpackage

// File: rtl/fb_scaled_addr_gen.sv
// Combinational display-coordinate to framebuffer-address mapping, plus the
// flag marking the cycles in which the display owns the RAM port.
module fb_scaled_addr_gen
  import fb_access_pkg::*;
#(
  parameter int BUF_WIDTH = 160,
  parameter int SCALE     = 4,
  parameter int ADDR_W    = 15
) (
  input  logic              i_display_active,
  input  logic [9:0]        i_display_x,
  input  logic [9:0]        i_display_y,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_display_slot
);

  localparam int         SHIFT     = fb_scale_log2(SCALE);
  localparam int         SUM_W     = ADDR_W + 1;
  localparam logic [9:0] SLOT_MASK = 10'(SCALE - 1);

  logic [9:0]       w_col;
  logic [9:0]       w_row;
  logic [SUM_W-1:0] w_sum;

  assign w_col = i_display_x >> SHIFT;
  assign w_row = i_display_y >> SHIFT;

  // One bit of headroom, then truncated; active coordinates never leave the buffer.
  assign w_sum  = SUM_W'(w_row) * SUM_W'(BUF_WIDTH) + SUM_W'(w_col);
  assign o_addr = w_sum[ADDR_W-1:0];

  assign o_display_slot = i_display_active && ((i_display_x & SLOT_MASK) == 10'd0);

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port framebuffer arbiter: display reads have absolute priority, and the
// remaining slots go to the draw-side writer or to the whole-buffer clear engine.
module fb_access_arbiter
  import fb_access_pkg::*;
#(
  parameter int BUF_WIDTH  = 160,
  parameter int BUF_HEIGHT = 120,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int DATA_W     = 12,
  parameter int ADDR_W     = fb_addr_width(BUF_WIDTH, BUF_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              display_active,
  input  logic [9:0]        display_x,
  input  logic [9:0]        display_y,
  output logic [DATA_W-1:0] pixel_out,
  output logic              pixel_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                SCALE     = fb_scale_factor(BUF_WIDTH, BUF_HEIGHT, H_RES, V_RES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BUF_WIDTH * BUF_HEIGHT - 1);

  fb_arb_state_t     r_state;
  fb_arb_state_t     w_state_next;
  logic [ADDR_W-1:0] r_clear_cnt;
  logic [DATA_W-1:0] r_clear_color;
  logic              r_clear_done;
  logic              r_act_d1;
  logic              r_slot_d1;
  logic              r_pixel_valid;
  logic [DATA_W-1:0] r_pixel;

  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_slot;
  logic              w_clear_write;
  logic              w_clear_last;

  fb_scaled_addr_gen #(
    .BUF_WIDTH (BUF_WIDTH),
    .SCALE     (SCALE),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .i_display_active (display_active),
    .i_display_x      (display_x),
    .i_display_y      (display_y),
    .o_addr           (w_rd_addr),
    .o_display_slot   (w_slot)
  );

  assign w_clear_write = (r_state == CLEAR) && !w_slot;
  assign w_clear_last  = w_clear_write && (r_clear_cnt == LAST_ADDR);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (clear_start)  w_state_next = CLEAR;
      CLEAR:   if (w_clear_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Port mux; everything is forced quiet while reset is held.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_ready  = 1'b0;
    if (rst_n) begin
      if (w_slot) begin
        mem_en   = 1'b1;
        mem_addr = w_rd_addr;
      end else if (r_state == IDLE) begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = wr_addr;
          mem_wdata = wr_data;
        end
      end else begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_clear_cnt;
        mem_wdata = r_clear_color;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_clear_cnt   <= '0;
      r_clear_color <= '0;
      r_clear_done  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_clear_done <= w_clear_last;
      if ((r_state == IDLE) && clear_start) begin
        r_clear_cnt   <= '0;
        r_clear_color <= clear_color;
      end else if (w_clear_write) begin
        r_clear_cnt <= r_clear_cnt + ADDR_W'(1);
      end
    end
  end

  // RAM data arrives one clock after the read; it is captured on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_d1      <= 1'b0;
      r_slot_d1     <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_pixel       <= '0;
    end else begin
      r_act_d1      <= display_active;
      r_slot_d1     <= w_slot;
      r_pixel_valid <= r_act_d1;
      if (!r_act_d1)      r_pixel <= '0;
      else if (r_slot_d1) r_pixel <= mem_rdata;
    end
  end

  assign pixel_out   = r_pixel;
  assign pixel_valid = r_pixel_valid;
  assign clear_busy  = (r_state == CLEAR);
  assign clear_done  = r_clear_done;

endmodule
